cdb_arbiter: RTL and testbench

- Round-robin arbiter for the single common data bus (CDB) shared by the 4 functional units (FUs) fed from the reservation stations.
- Each cycle it grants at most one completing FU, registers that FU's ROB tag and value, and broadcasts them for one cycle.
- The broadcast drives the ROB write port, RS tag-match wakeup and the decode-stage completion bypass (completion tag/value, robWriteEn).

---
 rtl/cdb_arbiter_if.sv | 36 +++
 rtl/cdb_arbiter.sv | 75 +++++++
 tb/tb_cdb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Common data bus port bundle: per-FU completion requests with their tag and
// value, the one-hot grant back to the FUs, the stall/flush controls and the
// registered broadcast. The master side is the FU/ROB environment, the slave
// side is the arbiter.
//
// Handshake: fuReq[n] is a valid, fuGrant[n] is its ready. FU n holds fuReq[n],
// fuTag[n] and fuVal[n] stable until a cycle with fuGrant[n]=1; the transfer
// happens on the rising edge closing that cycle, and the FU may drop the
// request or present a new result from the next cycle on.
interface cdb_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 4
);
    logic [NUM_FU-1:0]             fuReq;
    logic [NUM_FU-1:0][TAG_W-1:0]  fuTag;
    logic [NUM_FU-1:0][64:0]       fuVal;
    logic [NUM_FU-1:0]             fuGrant;
    logic                          cdbStall;
    logic                          flush;
    logic                          cdbValid;
    logic [TAG_W-1:0]              cdbTag;
    logic [64:0]                   cdbVal;
    logic [1:0]                    cdbSrc;
    logic                          tagErr;
    logic [1:0]                    dbg_ptr;   // round-robin pointer, observation only

    modport master (
        output fuReq, fuTag, fuVal, cdbStall, flush,
        input  fuGrant, cdbValid, cdbTag, cdbVal, cdbSrc, tagErr, dbg_ptr
    );

    modport slave (
        input  fuReq, fuTag, fuVal, cdbStall, flush,
        output fuGrant, cdbValid, cdbTag, cdbVal, cdbSrc, tagErr, dbg_ptr
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus. Picks at most one completing FU
// per cycle, starting the search at the priority pointer, and broadcasts the
// winner's ROB tag and value one cycle later. Tag 0 is never broadcast; a
// granted tag-0 result is consumed and raises a sticky error flag.
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int ROBsize    = 8,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input logic        clk_i,
    input logic        reset_i,
    cdb_arbiter_if.slave bus
);

    logic [1:0]            ptr;
    logic [1:0]            win_idx;
    logic [1:0]            idx;
    logic                  found;
    logic [NUM_FU-1:0]     grant;
    logic [ROBsizeLog-1:0] win_tag;

    // Grant search: first requester at ptr, ptr+1, ... (mod 4); nothing while
    // in reset, stalled or flushing.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        idx     = '0;
        found   = 1'b0;
        if (reset_i && !bus.cdbStall && !bus.flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                idx = ptr + 2'(i);
                if (!found && bus.fuReq[idx]) begin
                    found        = 1'b1;
                    win_idx      = idx;
                    grant[idx]   = 1'b1;
                end
            end
        end
    end

    assign win_tag     = bus.fuTag[win_idx];
    assign bus.fuGrant = grant;
    assign bus.dbg_ptr = ptr;

    // Pointer and broadcast register; flush beats stall, stall freezes all.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr          <= '0;
            bus.cdbValid <= 1'b0;
            bus.cdbTag   <= '0;
            bus.cdbVal   <= '0;
            bus.cdbSrc   <= '0;
            bus.tagErr   <= 1'b0;
        end else if (bus.flush) begin
            ptr          <= '0;
            bus.cdbValid <= 1'b0;
        end else if (!bus.cdbStall) begin
            if (found) begin
                ptr <= win_idx + 2'd1;
                if (win_tag != '0) begin
                    bus.cdbValid <= 1'b1;
                    bus.cdbTag   <= win_tag;
                    bus.cdbVal   <= bus.fuVal[win_idx];
                    bus.cdbSrc   <= win_idx;
                end else begin
                    bus.cdbValid <= 1'b0;
                    bus.tagErr   <= 1'b1;
                end
            end else begin
                bus.cdbValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single request, round-robin sweep,
// stall hold, tag-0 error, flush and asynchronous reset mid-broadcast.
module tb_cdb_arbiter;

    localparam int NUM_FU = 4;
    localparam int TAG_W  = 4;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    cdb_arbiter_if #(.NUM_FU(NUM_FU), .TAG_W(TAG_W)) bus ();

    cdb_arbiter #(.NUM_FU(NUM_FU), .ROBsize(8)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver helpers: advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.fuReq    = '0;
        bus.fuTag    = '0;
        bus.fuVal    = '0;
        bus.cdbStall = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic set_fu(input int n, input logic [TAG_W-1:0] tag, input logic [64:0] val);
        bus.fuReq[n] = 1'b1;
        bus.fuTag[n] = tag;
        bus.fuVal[n] = val;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        bus.fuReq = 4'b1111;
        bus.fuTag = {4'd4, 4'd3, 4'd2, 4'd1};
        #1;
        tests_run++;
        if (bus.fuGrant !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_grant: got %b expected 0000", bus.fuGrant);
        end
        tests_run++;
        if ({bus.cdbValid, bus.cdbTag, bus.cdbVal, bus.cdbSrc, bus.tagErr, bus.dbg_ptr} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b tag=%h val=%h src=%0d err=%b ptr=%0d expected all 0",
                     bus.cdbValid, bus.cdbTag, bus.cdbVal, bus.cdbSrc, bus.tagErr, bus.dbg_ptr);
        end
        clear_inputs();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (bus.fuGrant !== 4'b0000) begin
                tests_failed++;
                $display("FAIL idle_grant[%0d]: got %b expected 0000", c, bus.fuGrant);
            end
            step();
            tests_run++;
            if (bus.cdbValid !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_valid[%0d]: got %b expected 0", c, bus.cdbValid);
            end
        end
    endtask

    task automatic test_single();
        set_fu(2, 4'd3, 65'hAA);
        #1;
        tests_run++;
        if (bus.fuGrant !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_grant: got %b expected 0100", bus.fuGrant);
        end
        step();
        clear_inputs();
        tests_run++;
        if (bus.cdbValid !== 1'b1 || bus.cdbTag !== 4'd3 || bus.cdbVal !== 65'hAA || bus.cdbSrc !== 2'd2) begin
            tests_failed++;
            $display("FAIL single_bcast: valid=%b tag=%0d val=%h src=%0d expected 1/3/aa/2",
                     bus.cdbValid, bus.cdbTag, bus.cdbVal, bus.cdbSrc);
        end
        tests_run++;
        if (bus.dbg_ptr !== 2'd3) begin
            tests_failed++;
            $display("FAIL single_ptr: got %0d expected 3", bus.dbg_ptr);
        end
        step();
        tests_run++;
        if (bus.cdbValid !== 1'b0 || bus.cdbTag !== 4'd3 || bus.cdbSrc !== 2'd2) begin
            tests_failed++;
            $display("FAIL single_drop: valid=%b tag=%0d src=%0d expected 0/3/2",
                     bus.cdbValid, bus.cdbTag, bus.cdbSrc);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g;
        logic [64:0] exp_v;
        apply_reset();
        for (int n = 0; n < NUM_FU; n++)
            set_fu(n, 4'(n + 1), {1'b1, 60'h0, 4'(n + 8)});
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            exp_v = {1'b1, 60'h0, 4'((k % 4) + 8)};
            #1;
            tests_run++;
            if (bus.fuGrant !== exp_g) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.fuGrant, exp_g);
            end
            step();
            tests_run++;
            if (bus.cdbValid !== 1'b1 || bus.cdbTag !== 4'((k % 4) + 1) ||
                bus.cdbSrc !== 2'(k % 4) || bus.cdbVal !== exp_v) begin
                tests_failed++;
                $display("FAIL rr_bcast[%0d]: valid=%b tag=%0d src=%0d val=%h expected 1/%0d/%0d/%h",
                         k, bus.cdbValid, bus.cdbTag, bus.cdbSrc, bus.cdbVal, (k % 4) + 1, k % 4, exp_v);
            end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_stall();
        // ptr=1 here: FU3 alone is granted and broadcasts tag 5, ptr wraps to 0
        set_fu(3, 4'd5, 65'h55);
        step();
        clear_inputs();
        set_fu(1, 4'd6, 65'h66);
        bus.cdbStall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (bus.fuGrant !== 4'b0000) begin
                tests_failed++;
                $display("FAIL stall_grant[%0d]: got %b expected 0000", c, bus.fuGrant);
            end
            step();
            tests_run++;
            if (bus.cdbValid !== 1'b1 || bus.cdbTag !== 4'd5 || bus.cdbSrc !== 2'd3) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: valid=%b tag=%0d src=%0d expected 1/5/3",
                         c, bus.cdbValid, bus.cdbTag, bus.cdbSrc);
            end
        end
        bus.cdbStall = 1'b0;
        #1;
        tests_run++;
        if (bus.fuGrant !== 4'b0010) begin
            tests_failed++;
            $display("FAIL stall_release_grant: got %b expected 0010", bus.fuGrant);
        end
        step();
        clear_inputs();
        tests_run++;
        if (bus.cdbValid !== 1'b1 || bus.cdbTag !== 4'd6 || bus.cdbSrc !== 2'd1 || bus.cdbVal !== 65'h66) begin
            tests_failed++;
            $display("FAIL stall_next_bcast: valid=%b tag=%0d src=%0d val=%h expected 1/6/1/66",
                     bus.cdbValid, bus.cdbTag, bus.cdbSrc, bus.cdbVal);
        end
        step();
        tests_run++;
        if (bus.cdbValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_drop: got %b expected 0", bus.cdbValid);
        end
    endtask

    task automatic test_tag_zero();
        // ptr=2: search 2,3,0 lands on FU0
        set_fu(0, 4'd0, 65'h1234);
        #1;
        tests_run++;
        if (bus.fuGrant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL tag0_grant: got %b expected 0001", bus.fuGrant);
        end
        step();
        clear_inputs();
        tests_run++;
        if (bus.cdbValid !== 1'b0 || bus.tagErr !== 1'b1 || bus.cdbTag !== 4'd6 || bus.dbg_ptr !== 2'd1) begin
            tests_failed++;
            $display("FAIL tag0_result: valid=%b err=%b tag=%0d ptr=%0d expected 0/1/6/1",
                     bus.cdbValid, bus.tagErr, bus.cdbTag, bus.dbg_ptr);
        end
        step();
        step();
        tests_run++;
        if (bus.tagErr !== 1'b1) begin
            tests_failed++;
            $display("FAIL tag0_sticky: got %b expected 1", bus.tagErr);
        end
    endtask

    task automatic test_flush();
        // ptr=1: FU1 broadcasts tag 7, leaving ptr=2 and cdbValid=1
        set_fu(1, 4'd7, 65'h77);
        step();
        clear_inputs();
        tests_run++;
        if (bus.cdbValid !== 1'b1 || bus.dbg_ptr !== 2'd2) begin
            tests_failed++;
            $display("FAIL flush_setup: valid=%b ptr=%0d expected 1/2", bus.cdbValid, bus.dbg_ptr);
        end
        set_fu(3, 4'd2, 65'h22);
        bus.flush    = 1'b1;
        bus.cdbStall = 1'b1;
        #1;
        tests_run++;
        if (bus.fuGrant !== 4'b0000) begin
            tests_failed++;
            $display("FAIL flush_grant: got %b expected 0000", bus.fuGrant);
        end
        step();
        bus.flush    = 1'b0;
        bus.cdbStall = 1'b0;
        tests_run++;
        if (bus.cdbValid !== 1'b0 || bus.dbg_ptr !== 2'd0) begin
            tests_failed++;
            $display("FAIL flush_clear: valid=%b ptr=%0d expected 0/0", bus.cdbValid, bus.dbg_ptr);
        end
        #1;
        tests_run++;
        if (bus.fuGrant !== 4'b1000) begin
            tests_failed++;
            $display("FAIL flush_regrant: got %b expected 1000", bus.fuGrant);
        end
        step();
        clear_inputs();
        tests_run++;
        if (bus.cdbValid !== 1'b1 || bus.cdbTag !== 4'd2 || bus.cdbSrc !== 2'd3 || bus.dbg_ptr !== 2'd0) begin
            tests_failed++;
            $display("FAIL flush_bcast: valid=%b tag=%0d src=%0d ptr=%0d expected 1/2/3/0",
                     bus.cdbValid, bus.cdbTag, bus.cdbSrc, bus.dbg_ptr);
        end
    endtask

    task automatic test_reset_mid();
        // ptr=0: FU2 alone broadcasts, ptr moves to 3, then reset mid-cycle
        set_fu(2, 4'd9, 65'h99);
        step();
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.cdbValid !== 1'b0 || bus.tagErr !== 1'b0 || bus.dbg_ptr !== 2'd0) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%b err=%b ptr=%0d expected 0/0/0",
                     bus.cdbValid, bus.tagErr, bus.dbg_ptr);
        end
        step();
        rst_n = 1'b1;
        for (int n = 0; n < NUM_FU; n++)
            set_fu(n, 4'(n + 1), 65'(n));
        #1;
        tests_run++;
        if (bus.fuGrant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_resume_grant: got %b expected 0001", bus.fuGrant);
        end
        step();
        clear_inputs();
        tests_run++;
        if (bus.cdbValid !== 1'b1 || bus.cdbSrc !== 2'd0 || bus.cdbTag !== 4'd1) begin
            tests_failed++;
            $display("FAIL reset_resume_bcast: valid=%b src=%0d tag=%0d expected 1/0/1",
                     bus.cdbValid, bus.cdbSrc, bus.cdbTag);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_tag_zero();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
